// File: rtl/disp_pkg.sv
// disp_pkg: constants, FSM states and the better-than rule
// shared by every disparity selector in the codebase.
package disp_pkg;

  localparam bit MODE_MIN = 1'b0;
  localparam bit MODE_MAX = 1'b1;

  localparam int CMP_W = 32;
  typedef logic [CMP_W-1:0] cmp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } disp_state_e;

  // a beats b: strictly better score, or equal score at lower index
  function automatic logic better(
    input logic mx,
    input cmp_t sa,
    input cmp_t ia,
    input cmp_t sb,
    input cmp_t ib
  );
    if (sa == sb) return ia < ib;
    return mx ? (sa > sb) : (sa < sb);
  endfunction

  function automatic cmp_t pick(
    input logic mx,
    input cmp_t a,
    input cmp_t b
  );
    return (mx ? (a > b) : (a < b)) ? a : b;
  endfunction

endpackage

// File: rtl/disparity_select_cand_reduce.sv
// cand_reduce: combinational best / second-best tournament tree
// over one beat of LANES scores, lower lane wins ties.
module cand_reduce #(
  parameter int SCORE_W  = 18,
  parameter int LANES    = 4,
  parameter int LW       = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int MODE_MAX = 0
) (
  input  logic [LANES*SCORE_W-1:0] i_score,
  output logic [SCORE_W-1:0]       o_best,
  output logic [LW-1:0]            o_idx,
  output logic [SCORE_W-1:0]       o_sec,
  output logic                     o_sec_vld
);
  import disp_pkg::*;

  localparam logic SEL = (MODE_MAX != 0) ?
    disp_pkg::MODE_MAX : disp_pkg::MODE_MIN;
  localparam int N2 = 1 << $clog2(LANES);
  localparam int NN = 2 * N2;

  typedef logic [SCORE_W-1:0] score_t;

  function automatic void reduce(
    input  logic [LANES*SCORE_W-1:0] s,
    output score_t                   best,
    output logic [LW-1:0]            idx,
    output score_t                   sec,
    output logic                     sec_v
  );
    score_t        bs [NN];
    logic [LW-1:0] bi [NN];
    logic          bv [NN];
    score_t        ss [NN];
    logic          sv [NN];
    for (int n = 0; n < NN; n++) begin
      bs[n] = '0;
      bi[n] = '0;
      bv[n] = 1'b0;
      ss[n] = '0;
      sv[n] = 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      bs[N2+k] = s[k*SCORE_W +: SCORE_W];
      bi[N2+k] = LW'(k);
      bv[N2+k] = 1'b1;
    end
    // padding leaves sit on the right, so a valid right child
    // always has a valid left sibling
    for (int n = N2 - 1; n >= 1; n--) begin
      int w;
      int l;
      if (!bv[2*n+1]) begin
        bs[n] = bs[2*n];
        bi[n] = bi[2*n];
        bv[n] = bv[2*n];
        ss[n] = ss[2*n];
        sv[n] = sv[2*n];
      end else begin
        w = better(SEL,
                   cmp_t'(bs[2*n]), cmp_t'(bi[2*n]),
                   cmp_t'(bs[2*n+1]), cmp_t'(bi[2*n+1]))
            ? 2*n : 2*n + 1;
        l = w ^ 1;
        bs[n] = bs[w];
        bi[n] = bi[w];
        bv[n] = 1'b1;
        ss[n] = sv[w]
              ? score_t'(pick(SEL, cmp_t'(bs[l]), cmp_t'(ss[w])))
              : bs[l];
        sv[n] = 1'b1;
      end
    end
    best  = bs[1];
    idx   = bi[1];
    sec   = ss[1];
    sec_v = sv[1];
  endfunction

  always_comb begin
    reduce(i_score, o_best, o_idx, o_sec, o_sec_vld);
  end

endmodule

// File: rtl/disparity_select.sv
// disparity_select: streams NUM_CAND scores in LANES-wide beats and
// reports the best index, its score and the margin to second-best.
module disparity_select #(
  parameter int SCORE_W  = 18,
  parameter int NUM_CAND = 64,
  parameter int LANES    = 4,
  parameter int IDX_W    = 8,
  parameter int MODE_MAX = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*SCORE_W-1:0] in_score,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [SCORE_W-1:0]       out_score,
  output logic [SCORE_W-1:0]       out_margin
);
  import disp_pkg::*;

  localparam int LN = (LANES < 1) ? 1 : LANES;
  localparam int NB = NUM_CAND / LN;
  localparam int CW = $clog2(NB) + 1;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
  localparam logic SEL = (MODE_MAX != 0) ?
    disp_pkg::MODE_MAX : disp_pkg::MODE_MIN;

  if (LANES < 1) begin : g_bad_lanes
    $error("disparity_select: LANES must be >= 1");
  end
  if ((NUM_CAND % LN) != 0) begin : g_bad_div
    $error("disparity_select: NUM_CAND not a multiple of LANES");
  end
  if ((longint'(1) << IDX_W) < longint'(NUM_CAND)) begin : g_bad_idx
    $error("disparity_select: IDX_W too narrow for NUM_CAND");
  end

  typedef logic [SCORE_W-1:0] score_t;

  disp_state_e   r_state;
  disp_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_bidx;

  logic          w_acc;
  logic          w_first;
  logic          w_last;

  score_t        w_l_best;
  logic [LW-1:0] w_l_idx;
  score_t        w_l_sec;
  logic          w_l_sec_vld;
  logic [IDX_W-1:0] w_gidx;

  score_t        w_m_best;
  logic [IDX_W-1:0] w_m_idx;
  score_t        w_m_sec;
  logic          w_m_sec_vld;
  score_t        w_margin;

  score_t        r_best;
  logic [IDX_W-1:0] r_idx;
  score_t        r_sec;
  logic          r_sec_vld;

  logic [IDX_W-1:0] r_out_idx;
  score_t        r_out_score;
  score_t        r_out_margin;

  cand_reduce #(
    .SCORE_W  (SCORE_W),
    .LANES    (LN),
    .LW       (LW),
    .MODE_MAX (MODE_MAX)
  ) u_reduce (
    .i_score   (in_score),
    .o_best    (w_l_best),
    .o_idx     (w_l_idx),
    .o_sec     (w_l_sec),
    .o_sec_vld (w_l_sec_vld)
  );

  assign in_ready  = (r_state != ST_HOLD) || out_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_idx    = r_out_idx;
  assign out_score  = r_out_score;
  assign out_margin = r_out_margin;

  // any beat taken outside ACCUM starts a fresh search
  assign w_acc   = in_valid && in_ready;
  assign w_first = (r_state != ST_ACCUM);
  assign w_bidx  = w_first ? '0 : r_cnt;
  assign w_last  = (w_bidx == CW'(NB - 1));
  assign w_gidx  = IDX_W'(w_bidx) * IDX_W'(LN)
                 + IDX_W'(w_l_idx);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc)
          w_state_nxt = w_last ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_acc && w_last)
          w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (w_acc)
            w_state_nxt = w_last ? ST_HOLD : ST_ACCUM;
          else
            w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_acc)
      w_cnt_nxt = w_last ? '0 : w_bidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // running candidates always carry lower indices than the beat
  always_comb begin
    w_m_best    = w_l_best;
    w_m_idx     = w_gidx;
    w_m_sec     = w_l_sec;
    w_m_sec_vld = w_l_sec_vld;
    if (!w_first) begin
      w_m_sec_vld = 1'b1;
      if (better(SEL, cmp_t'(r_best), cmp_t'(r_idx),
                 cmp_t'(w_l_best), cmp_t'(w_gidx))) begin
        w_m_best = r_best;
        w_m_idx  = r_idx;
        w_m_sec  = r_sec_vld
                 ? score_t'(pick(SEL, cmp_t'(r_sec),
                                 cmp_t'(w_l_best)))
                 : w_l_best;
      end else begin
        w_m_sec  = w_l_sec_vld
                 ? score_t'(pick(SEL, cmp_t'(w_l_sec),
                                 cmp_t'(r_best)))
                 : r_best;
      end
    end
  end

  always_comb begin
    w_margin = '0;
    if (w_m_sec_vld)
      w_margin = SEL ? (w_m_best - w_m_sec)
                     : (w_m_sec - w_m_best);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best       <= '0;
      r_idx        <= '0;
      r_sec        <= '0;
      r_sec_vld    <= 1'b0;
      r_out_idx    <= '0;
      r_out_score  <= '0;
      r_out_margin <= '0;
    end else begin
      if (w_acc) begin
        r_best    <= w_m_best;
        r_idx     <= w_m_idx;
        r_sec     <= w_m_sec;
        r_sec_vld <= w_m_sec_vld;
      end
      if (w_acc && w_last) begin
        r_out_idx    <= w_m_idx;
        r_out_score  <= w_m_best;
        r_out_margin <= w_margin;
      end
    end
  end

endmodule
